// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - ALUCtrl decode/issue stage with multi-cycle MUL stall
// Optional illegal_o output when ALU_CTRL_ILLEGAL_EN is defined.
module alu_ctrl_issue #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] ALUOp_i,
  input  logic [5:0] funct_i,
  input  logic       flush_i,
  output logic [2:0] ALUCtrl_o,
  output logic       valid_o,
  output logic       stall_o
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic       illegal_o
`endif
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  localparam logic [2:0] CODE_MUL = 3'b011;
  localparam logic [2:0] CODE_BAD = 3'b111;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] code, ctrl_n;
  logic       valid_n;

  always_comb begin
    code = 3'b010;
    case (ALUOp_i)
      2'b00: code = 3'b010;
      2'b01: code = 3'b110;
      2'b11: code = 3'b001;
      default: begin
        case (funct_i)
          6'h20:   code = 3'b010;
          6'h22:   code = 3'b110;
          6'h24:   code = 3'b000;
          6'h25:   code = 3'b001;
          6'h18:   code = CODE_MUL;
          default: code = CODE_BAD;
        endcase
      end
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctrl_n  = ALUCtrl_o;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && !flush_i) begin
          ctrl_n = code;
          // A single-cycle MUL behaves exactly like any other op.
          if (code == CODE_MUL && MUL_CYCLES > 1) begin
            cnt_n   = MUL_LOAD;
            state_n = MUL_BUSY;
          end else begin
            valid_n = 1'b1;
          end
        end
      end
      default: begin
        ctrl_n = CODE_MUL;
        if (flush_i) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = IDLE;
            valid_n = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_n;

  always_comb begin
    illegal_n = 1'b0;
    if (state == IDLE && valid_i && !flush_i && ALUOp_i == 2'b10 && code == CODE_BAD)
      illegal_n = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) illegal_o <= 1'b0;
    else       illegal_o <= illegal_n;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ALUCtrl_o <= 3'b000;
      valid_o   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ALUCtrl_o <= ctrl_n;
      valid_o   <= valid_n;
    end
  end

  assign stall_o = (state == MUL_BUSY);

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - scoreboard bench for alu_ctrl_issue
module tb_alu_ctrl_issue;
  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst, valid, flush;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [2:0] ctrl;
  logic       vout, stall;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       illegal;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  alu_ctrl_issue #(.MUL_CYCLES(MC)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .ALUOp_i   (aluop),
    .funct_i   (funct),
    .flush_i   (flush),
    .ALUCtrl_o (ctrl),
    .valid_o   (vout),
    .stall_o   (stall)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal_o (illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] model_code(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00: return 3'b010;
      2'b01: return 3'b110;
      2'b11: return 3'b001;
      default:
        case (fn)
          6'h20:   return 3'b010;
          6'h22:   return 3'b110;
          6'h24:   return 3'b000;
          6'h25:   return 3'b001;
          6'h18:   return 3'b011;
          default: return 3'b111;
        endcase
    endcase
  endfunction

  // Every valid_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && vout === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_spurious", 1, 0);
      end else begin
        logic [3:0] e;
        e = sb_q.pop_front();
        check("sb_code", 32'(ctrl), 32'(e[2:0]));
`ifdef ALU_CTRL_ILLEGAL_EN
        check("sb_illegal", 32'(illegal), 32'(e[3]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn);
    logic [2:0] c;
    c = model_code(op, fn);
    aluop = op; funct = fn; valid = 1'b1; flush = 1'b0;
    sb_q.push_back({(op == 2'b10 && c == 3'b111), c});
    tick();
    if (c == 3'b011 && MC > 1) begin
      for (int i = 1; i < MC; i++) begin
        check("mul_stall", 32'(stall), 1);
        check("mul_ctrl", 32'(ctrl), 3);
        check("mul_valid", 32'(vout), 0);
        tick();
      end
    end
    check("issue_stall", 32'(stall), 0);
    check("issue_valid", 32'(vout), 1);
  endtask

  task automatic idle();
    valid = 1'b0; flush = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] fns[6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h3F};

    rst = 1'b1; valid = 1'b1; aluop = 2'b10; funct = 6'h20; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ctrl", 32'(ctrl), 0);
      check("rst_valid", 32'(vout), 0);
      check("rst_stall", 32'(stall), 0);
    end
    rst = 1'b0;
    idle();

    issue(2'b10, 6'h22);
    check("sub_ctrl", 32'(ctrl), 6);

    issue(2'b10, 6'h18);
    issue(2'b10, 6'h25);
    check("b2b_ctrl", 32'(ctrl), 1);
    idle();

    issue(2'b00, 6'h00);
    issue(2'b01, 6'h3F);
    issue(2'b11, 6'h18);
    issue(2'b10, 6'h24);
    issue(2'b10, 6'h20);
    idle();

    // Flush in the middle of a MUL.
    aluop = 2'b10; funct = 6'h18; valid = 1'b1;
    tick(); tick();
    valid = 1'b0; flush = 1'b1;
    tick();
    check("flush_stall", 32'(stall), 0);
    check("flush_valid", 32'(vout), 0);
    check("flush_ctrl", 32'(ctrl), 3);
    idle();
    issue(2'b10, 6'h24);
    idle();

    // Flush coinciding with the final MUL cycle cancels completion.
    aluop = 2'b10; funct = 6'h18; valid = 1'b1;
    tick(); tick(); tick();
    valid = 1'b0; flush = 1'b1;
    tick();
    check("flush_last_valid", 32'(vout), 0);
    check("flush_last_stall", 32'(stall), 0);

    // Flush with a request in IDLE drops it and holds ALUCtrl_o.
    aluop = 2'b10; funct = 6'h20; valid = 1'b1; flush = 1'b1;
    tick();
    check("flush_idle_valid", 32'(vout), 0);
    check("flush_idle_ctrl", 32'(ctrl), 3);
    check("flush_idle_stall", 32'(stall), 0);
    idle();

    // Reset in the middle of a MUL.
    aluop = 2'b10; funct = 6'h18; valid = 1'b1;
    tick(); tick();
    rst = 1'b1; valid = 1'b0;
    tick();
    check("rst_mul_stall", 32'(stall), 0);
    check("rst_mul_valid", 32'(vout), 0);
    check("rst_mul_ctrl", 32'(ctrl), 0);
    rst = 1'b0;
    idle();

    issue(2'b10, 6'h3F);
    check("bad_ctrl", 32'(ctrl), 7);
    idle();

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 5)];
      issue(op, fn);
      if ($urandom_range(0, 3) == 0) idle();
    end

    idle(); idle(); idle();
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
